axis_spi_reg_bridge: RTL and testbench
======================================

# axis_spi_reg_bridge

Command decoder sitting directly downstream of `axis_spi`: consumes the received SPI byte stream (`axis_spi.m_axis_*`), decodes a one-byte command header, and drives a simple synchronous register bus. For reads it returns register bytes into `axis_spi.s_axis_*`, so they are shifted out on MISO during the following SPI byte. It is the single register-access path from the Pi host into the FPGA.

## Interface
- `ADDR_W`, 7: register address width; the command byte carries it in bits [6:0].
- `DATA_W`, 8: data width; must equal the stream byte width.
- `axis_aclk` in 1: single clock for all logic.
- `axis_aresetn` in 1: reset, synchronous and active-low.
- `s_axis_tdata` in 8: received SPI byte.
- `s_axis_tvalid` in 1: received byte valid.
- `s_axis_tready` out 1: bridge accepts the byte.
- `s_axis_tuser` in 1: marks the first byte after CS falls (frame start).
- `s_axis_tkeep`, `s_axis_tlast` in 1 each: ignored.
- `m_axis_tdata` out 8: byte to transmit on MISO.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1: transmit handshake.
- `m_axis_tkeep` out 1: equals `m_axis_tvalid`. `m_axis_tlast` and `m_axis_tuser` out 1 each: tied to 0.
- `reg_addr` out ADDR_W, `reg_wdata` out DATA_W: register bus address and write data.
- `reg_we` out 1, `reg_re` out 1: single-cycle strobes.
- `reg_rdata` in DATA_W: valid exactly one cycle after `reg_re`.
- `drop_count` out 8: saturating count of discarded bytes.

## Operation
- Command byte: bit7 = 1 means read, 0 means write; bits[6:0] give the start address. The address auto-increments after each data byte and wraps from 0x7F to 0x00.
- States:
  - IDLE: accept a byte with `tuser` = 1 and it becomes the command, going to WRITE or RD_REQ. A byte with `tuser` = 0 is dropped and `drop_count` increments.
  - WRITE: each accepted byte with `tuser` = 0 pulses `reg_we` with the current address and data, then the address increments. A byte with `tuser` = 1 is a new command; no write happens for it.
  - RD_REQ: pulse `reg_re` for one cycle, then go to RD_WAIT.
  - RD_WAIT: capture `reg_rdata` into `m_axis_tdata`, then go to RD_PUSH.
  - RD_PUSH: hold `m_axis_tvalid` until `tready`; on the handshake the address increments and the state goes to RD_DUMMY.
  - RD_DUMMY: the next accepted byte with `tuser` = 0 is the master's clock byte. It is discarded without counting as a drop and the state goes to RD_REQ. A byte with `tuser` = 1 is a new command.
- `s_axis_tready` = 1 in IDLE, WRITE and RD_DUMMY; 0 in RD_REQ, RD_WAIT and RD_PUSH.
- `drop_count` saturates at 0xFF.
- Write data is never echoed on MISO; the bridge pushes nothing on `m_axis` during writes.

## Timing
- Reset values: all outputs 0, state IDLE, address 0, `drop_count` 0. Reset applied mid-frame discards any pending `m_axis` beat and any partial command.
- Write latency: byte accepted at edge N gives `reg_we`, `reg_addr` and `reg_wdata` registered high during cycle N+1, for exactly one cycle.
- Read latency: command accepted at edge N gives `reg_re` in cycle N+1, `reg_rdata` sampled at the end of N+2, and `m_axis_tvalid` high from cycle N+3.
- Total read latency is 3 `axis_aclk` cycles. This is far below one SPI byte time (8 SPI clocks at ≥10 aclk each), so data is queued before the next byte shifts.
- Per AXI-stream rules, `m_axis_tdata` is stable while `tvalid` is high and `tready` is low.
- `reg_we` and `reg_re` are never high in the same cycle.

## Structure
- Shared package `spi_bridge_pkg`: state enum, `CMD_RD_BIT` = 7, `ADDR_W`, `DATA_W`, and `DROP_MAX` = 8'hFF.
- Single module; no sub-module is needed. The register file sits outside the block and is addressed over `reg_*`.

## Test plan
1. Write burst: inbound 0x05 (tuser = 1), 0x11, 0x22 -> `reg_we` at address 0x05 with 0x11, then address 0x06 with 0x22; `m_axis_tvalid` stays 0.
2. Read burst: registers hold [0x10] = 0xAB and [0x11] = 0xCD. Inbound 0x90 (tuser = 1) -> `m_axis` beat 0xAB three cycles later. Inbound dummy 0x00 -> `m_axis` beat 0xCD.
3. Address wrap: write command 0x7F then 2 data bytes -> writes land at 0x7F and then 0x00.
4. Stray bytes: 3 bytes with tuser = 0 in IDLE -> no register strobes, `drop_count` = 3. 300 stray bytes -> `drop_count` = 0xFF.
5. Back-pressure and re-frame: hold `m_axis_tready` = 0 for 20 cycles in RD_PUSH -> `tdata` stays stable and `s_axis_tready` = 0. Then a byte with tuser = 1 arriving in WRITE is decoded as a new command with no stray write.
6. Reset mid-read: drop `axis_aresetn` during RD_WAIT -> all outputs 0 on the next edge; after release, a command 0x01 write works normally.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// ----------------------------------------------------------------------------
// spi_bridge_pkg
// Shared definitions for the SPI register bridge: the decoder state encoding,
// the bit positions inside the command byte and the bus widths.
// ----------------------------------------------------------------------------
package spi_bridge_pkg;

   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 8;
   localparam int CMD_RD_BIT = 7;

   localparam logic [7:0] DROP_MAX = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_RD_PUSH,
      ST_RD_DUMMY
   } state_t;

endpackage

// File: rtl/axis_spi_reg_bridge.sv
// ----------------------------------------------------------------------------
// axis_spi_reg_bridge
// Decodes the byte stream received from the SPI slave into register bus
// accesses. The first byte of a frame (tuser = 1) is a command: bit 7 selects
// read (1) or write (0), the low bits are the start address. Write frames
// carry data bytes that are strobed onto the register bus. Read frames return
// one register byte per SPI byte on the transmit stream, the master clocking
// each one out with a dummy byte.
//
// Ports
//   axis_aclk, axis_aresetn   clock, synchronous active-low reset
//   s_axis_*                  received SPI bytes (tkeep/tlast ignored)
//   m_axis_*                  bytes to shift out on MISO
//   reg_addr/reg_wdata        register bus address and write data
//   reg_we/reg_re             single-cycle write/read strobes
//   reg_rdata                 read data, valid one cycle after reg_re
//   drop_count                saturating count of bytes thrown away in IDLE
// ----------------------------------------------------------------------------
module axis_spi_reg_bridge #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              axis_aclk,
   input  logic              axis_aresetn,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tuser,
   input  logic              s_axis_tkeep,
   input  logic              s_axis_tlast,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tkeep,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic [7:0]        drop_count
);

   import spi_bridge_pkg::*;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_regAddr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_mData;
   logic              r_mValid;
   logic              r_sReady;
   logic              r_we;
   logic              r_re;
   logic [7:0]        r_drop;

   logic              w_accept;
   logic              w_cmdRead;
   logic [ADDR_W-1:0] w_cmdAddr;
   logic              w_unused;

   assign w_accept  = s_axis_tvalid & r_sReady;
   assign w_cmdRead = s_axis_tdata[CMD_RD_BIT];
   assign w_cmdAddr = s_axis_tdata[ADDR_W-1:0];
   assign w_unused  = s_axis_tkeep ^ s_axis_tlast;

   // Single decoder FSM. A frame-start byte is a new command in every state
   // that accepts bytes, so it is handled ahead of the per-state logic; this
   // also guarantees that a command byte can never cause a stray write.
   // s_axis_tready is a register set alongside each state change, so it reads
   // 0 while reset is held and rises one cycle after reset is released.
   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_regAddr <= '0;
         r_wdata   <= '0;
         r_mData   <= '0;
         r_mValid  <= 1'b0;
         r_sReady  <= 1'b0;
         r_we      <= 1'b0;
         r_re      <= 1'b0;
         r_drop    <= '0;
      end else begin
         r_we <= 1'b0;
         r_re <= 1'b0;
         if (w_accept && s_axis_tuser) begin
            r_addr <= w_cmdAddr;
            if (w_cmdRead) begin
               r_state   <= ST_RD_REQ;
               r_re      <= 1'b1;
               r_regAddr <= w_cmdAddr;
               r_sReady  <= 1'b0;
            end else begin
               r_state  <= ST_WRITE;
               r_sReady <= 1'b1;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_sReady <= 1'b1;
                  if (w_accept && (r_drop != DROP_MAX)) begin
                     r_drop <= r_drop + 8'd1;
                  end
               end
               ST_WRITE: begin
                  if (w_accept) begin
                     r_we      <= 1'b1;
                     r_regAddr <= r_addr;
                     r_wdata   <= s_axis_tdata;
                     r_addr    <= r_addr + ADDR_W'(1);
                  end
               end
               ST_RD_REQ: begin
                  r_state <= ST_RD_WAIT;
               end
               ST_RD_WAIT: begin
                  r_mData  <= reg_rdata;
                  r_mValid <= 1'b1;
                  r_state  <= ST_RD_PUSH;
               end
               ST_RD_PUSH: begin
                  if (m_axis_tready) begin
                     r_mValid <= 1'b0;
                     r_addr   <= r_addr + ADDR_W'(1);
                     r_sReady <= 1'b1;
                     r_state  <= ST_RD_DUMMY;
                  end
               end
               ST_RD_DUMMY: begin
                  if (w_accept) begin
                     r_state   <= ST_RD_REQ;
                     r_re      <= 1'b1;
                     r_regAddr <= r_addr;
                     r_sReady  <= 1'b0;
                  end
               end
               default: begin
                  r_state  <= ST_IDLE;
                  r_sReady <= 1'b0;
               end
            endcase
         end
      end
   end

   assign s_axis_tready = r_sReady;
   assign m_axis_tdata  = r_mData;
   assign m_axis_tvalid = r_mValid;
   assign m_axis_tkeep  = r_mValid;
   assign m_axis_tlast  = 1'b0;
   assign m_axis_tuser  = 1'b0;
   assign reg_addr      = r_regAddr;
   assign reg_wdata     = r_wdata;
   assign reg_we        = r_we;
   assign reg_re        = r_re;
   assign drop_count    = r_drop;

endmodule

// File: tb/tb_axis_spi_reg_bridge.sv
module tb_axis_spi_reg_bridge;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] sTdata = 8'h00;
   logic       sTvalid = 1'b0;
   logic       sTready;
   logic       sTuser = 1'b0;
   logic [7:0] mTdata;
   logic       mTvalid;
   logic       mTready = 1'b1;
   logic       mTkeep;
   logic       mTlast;
   logic       mTuser;
   logic [6:0] regAddr;
   logic [7:0] regWdata;
   logic       regWe;
   logic       regRe;
   logic [7:0] regRdata = 8'h00;
   logic [7:0] dropCount;

   logic [7:0] envMem [128] = '{default: 8'h00};

   int unsigned nVectors = 0;
   int unsigned nMiscompares = 0;
   bit          running = 1'b0;
   int          edgeCnt = 0;
   int          accEdge = 0;

   // Behavioural model of the bridge at byte/transaction level
   logic [7:0]  modelMem [128];
   int          mode = 0;
   logic [6:0]  mAddr = 7'h00;
   int          mDrops = 0;
   logic [14:0] expWr[$];
   logic [7:0]  expBeat[$];

   // Observations gathered by the compare process
   int          wrCnt = 0;
   int          beatCnt = 0;
   int          weEdge = -1;
   int          riseEdge = -1;
   logic [7:0]  lastBeat = 8'h00;
   logic        prevValid = 1'b0;
   logic        prevReady = 1'b0;
   logic [7:0]  prevData = 8'h00;

   axis_spi_reg_bridge #(.ADDR_W(7), .DATA_W(8)) dut (
      .axis_aclk     (clk),
      .axis_aresetn  (rstn),
      .s_axis_tdata  (sTdata),
      .s_axis_tvalid (sTvalid),
      .s_axis_tready (sTready),
      .s_axis_tuser  (sTuser),
      .s_axis_tkeep  (1'b1),
      .s_axis_tlast  (1'b0),
      .m_axis_tdata  (mTdata),
      .m_axis_tvalid (mTvalid),
      .m_axis_tready (mTready),
      .m_axis_tkeep  (mTkeep),
      .m_axis_tlast  (mTlast),
      .m_axis_tuser  (mTuser),
      .reg_addr      (regAddr),
      .reg_wdata     (regWdata),
      .reg_we        (regWe),
      .reg_re        (regRe),
      .reg_rdata     (regRdata),
      .drop_count    (dropCount)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Edge counter used to measure strobe and beat latency
   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   // External register file: writes land on the strobe, read data appears one cycle after reg_re
   always @(posedge clk) begin
      if (regWe) envMem[regAddr] <= regWdata;
      if (regRe) regRdata <= envMem[regAddr];
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clearModel();
      mode = 0;
      mAddr = 7'h00;
      mDrops = 0;
      expWr.delete();
      expBeat.delete();
   endtask

   // Apply the decoding rules to one accepted byte and queue what must appear on the buses
   task automatic modelAccept(input logic [7:0] data, input logic user);
      if (user) begin
         mAddr = data[6:0];
         if (data[7]) begin
            mode = 2;
            expBeat.push_back(modelMem[mAddr]);
            mAddr = mAddr + 7'd1;
         end else begin
            mode = 1;
         end
      end else if (mode == 0) begin
         if (mDrops < 255) mDrops++;
      end else if (mode == 1) begin
         expWr.push_back({mAddr, data});
         modelMem[mAddr] = data;
         mAddr = mAddr + 7'd1;
      end else begin
         expBeat.push_back(modelMem[mAddr]);
         mAddr = mAddr + 7'd1;
      end
   endtask

   // Offer one byte and hold it until the bridge accepts it (bounded)
   task automatic applyStimulus(input logic [7:0] data, input logic user);
      int budget;
      bit got;
      budget = 0;
      got = 1'b0;
      sTdata = data;
      sTuser = user;
      sTvalid = 1'b1;
      while (!got && budget < 200) begin
         @(negedge clk);
         if (sTready) got = 1'b1;
         else budget++;
      end
      if (!got) begin
         checkOutput("accept_timeout", 64'(got), 64'd1);
         sTvalid = 1'b0;
         sTuser = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         accEdge = edgeCnt;
         modelAccept(data, user);
         sTvalid = 1'b0;
         sTuser = 1'b0;
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitBeat(input int target);
      int budget;
      budget = 0;
      while (beatCnt < target && budget < 100) begin
         @(posedge clk);
         budget++;
      end
      #1;
      checkOutput("beat_timeout", 64'(beatCnt >= target), 64'd1);
   endtask

   task automatic applyReset();
      rstn = 1'b0;
      clearModel();
      waitCycles(2);
      rstn = 1'b1;
   endtask

   // Per-cycle compare against the model, sampled on the falling edge
   always @(negedge clk) begin
      if (!rstn || !running) begin
         prevValid = 1'b0;
      end else begin
         checkOutput("drop_count", 64'(dropCount), 64'(mDrops));
         checkOutput("keep_eq_valid", 64'(mTkeep), 64'(mTvalid));
         checkOutput("tlast_tuser", 64'({mTlast, mTuser}), 64'd0);
         checkOutput("we_re_overlap", 64'(regWe & regRe), 64'd0);
         if (regWe) begin
            weEdge = edgeCnt;
            wrCnt++;
            if (expWr.size() == 0) begin
               nVectors++;
               nMiscompares++;
               $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", regAddr, regWdata);
            end else begin
               checkOutput("write_addr_data", 64'({regAddr, regWdata}), 64'(expWr.pop_front()));
            end
         end
         if (mTvalid && !prevValid) riseEdge = edgeCnt;
         if (prevValid && !prevReady) begin
            checkOutput("hold_valid", 64'(mTvalid), 64'd1);
            checkOutput("hold_data", 64'(mTdata), 64'(prevData));
         end
         if (mTvalid && mTready) begin
            beatCnt++;
            lastBeat = mTdata;
            if (expBeat.size() == 0) begin
               nVectors++;
               nMiscompares++;
               $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat", mTdata);
            end else begin
               checkOutput("read_beat", 64'(mTdata), 64'(expBeat.pop_front()));
            end
         end
         prevValid = mTvalid;
         prevReady = mTready;
         prevData = mTdata;
      end
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 500us");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      int e;
      int w0;
      int b0;
      for (int i = 0; i < 128; i++) modelMem[i] = 8'h00;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_outputs",
                  64'({sTready, mTdata, mTvalid, mTkeep, mTlast, mTuser, regAddr, regWdata, regWe, regRe, dropCount}),
                  64'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      running = 1'b1;

      // Write burst at 0x05
      applyStimulus(8'h05, 1'b1);
      applyStimulus(8'h11, 1'b0);
      e = accEdge;
      applyStimulus(8'h22, 1'b0);
      waitCycles(3);
      checkOutput("write_latency", 64'(weEdge - accEdge), 64'd0);
      checkOutput("mem05", 64'(envMem[7'h05]), 64'h11);
      checkOutput("mem06", 64'(envMem[7'h06]), 64'h22);
      checkOutput("write_count", 64'(wrCnt), 64'd2);
      checkOutput("no_beat_on_write", 64'(beatCnt), 64'd0);
      checkOutput("first_write_edge", 64'(accEdge - e > 0), 64'd1);

      // Read burst from 0x10 after loading 0xAB, 0xCD
      applyStimulus(8'h10, 1'b1);
      applyStimulus(8'hAB, 1'b0);
      applyStimulus(8'hCD, 1'b0);
      applyStimulus(8'h90, 1'b1);
      e = accEdge;
      waitBeat(1);
      checkOutput("read_latency", 64'(riseEdge - e), 64'd2);
      checkOutput("read_beat0", 64'(lastBeat), 64'hAB);
      applyStimulus(8'h00, 1'b0);
      waitBeat(2);
      checkOutput("read_beat1", 64'(lastBeat), 64'hCD);

      // Address wrap from 0x7F
      applyStimulus(8'h7F, 1'b1);
      applyStimulus(8'hE1, 1'b0);
      applyStimulus(8'hE2, 1'b0);
      waitCycles(3);
      checkOutput("mem7f", 64'(envMem[7'h7F]), 64'hE1);
      checkOutput("mem00", 64'(envMem[7'h00]), 64'hE2);

      // Stray bytes in IDLE
      applyReset();
      w0 = wrCnt;
      for (int i = 0; i < 3; i++) applyStimulus(8'h33, 1'b0);
      waitCycles(2);
      checkOutput("drop_3", 64'(dropCount), 64'h03);
      for (int i = 0; i < 300; i++) applyStimulus(8'(i), 1'b0);
      waitCycles(2);
      checkOutput("drop_sat", 64'(dropCount), 64'hFF);
      checkOutput("stray_no_write", 64'(wrCnt - w0), 64'd0);

      // Back-pressure on a read, then re-framing inside a write
      applyStimulus(8'h20, 1'b1);
      applyStimulus(8'h5A, 1'b0);
      mTready = 1'b0;
      applyStimulus(8'hA0, 1'b1);
      b0 = beatCnt;
      waitCycles(4);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("bp_valid", 64'(mTvalid), 64'd1);
         checkOutput("bp_data", 64'(mTdata), 64'h5A);
         checkOutput("bp_s_ready", 64'(sTready), 64'd0);
      end
      @(posedge clk);
      #1;
      mTready = 1'b1;
      waitBeat(b0 + 1);
      checkOutput("bp_beat", 64'(lastBeat), 64'h5A);
      w0 = wrCnt;
      applyStimulus(8'h30, 1'b1);
      applyStimulus(8'h77, 1'b0);
      applyStimulus(8'h32, 1'b1);
      applyStimulus(8'h88, 1'b0);
      waitCycles(3);
      checkOutput("mem30", 64'(envMem[7'h30]), 64'h77);
      checkOutput("mem31", 64'(envMem[7'h31]), 64'h00);
      checkOutput("mem32", 64'(envMem[7'h32]), 64'h88);
      checkOutput("reframe_writes", 64'(wrCnt - w0), 64'd2);

      // Reset while the read data is being fetched
      applyStimulus(8'h40, 1'b1);
      applyStimulus(8'h3C, 1'b0);
      applyStimulus(8'hC0, 1'b1);
      b0 = beatCnt;
      @(posedge clk);
      #1;
      rstn = 1'b0;
      clearModel();
      @(posedge clk);
      #1;
      checkOutput("midread_reset_outputs",
                  64'({sTready, mTdata, mTvalid, mTkeep, mTlast, mTuser, regAddr, regWdata, regWe, regRe, dropCount}),
                  64'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      applyStimulus(8'h01, 1'b1);
      applyStimulus(8'h99, 1'b0);
      waitCycles(6);
      checkOutput("mem01_after_reset", 64'(envMem[7'h01]), 64'h99);
      checkOutput("discarded_beat", 64'(beatCnt - b0), 64'd0);

      checkOutput("pending_writes", 64'(expWr.size()), 64'd0);
      checkOutput("pending_beats", 64'(expBeat.size()), 64'd0);

      running = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
